// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM; define CTRL_EXT_BRANCH_EN for blt/bge/bltu/bgeu
module multicycle_control_unit #(
   parameter int ALUCTRL_W = 3,
   parameter int MEM_LAT   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic                 Zero,
   input  logic                 Neg,
   input  logic                 Ovf,
   input  logic                 Carry,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [2:0]           ImmSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [3:0]           state_o,
   output logic                 illegal_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALRADR  = 4'd11,
      S_EXECU    = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_SLT  = 4'h5;
   localparam logic [3:0] ALU_SLL  = 4'h6;
   localparam logic [3:0] ALU_SRL  = 4'h7;
   localparam logic [3:0] ALU_SRA  = 4'h8;
   localparam logic [3:0] ALU_SLTU = 4'h9;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] funct_alu;
   logic       alu_ok;
   logic       br_legal, br_taken;
   logic       last_cycle;
   logic       pcw_en, irw_en, mem_en, reg_en;

   // memory-facing states hold for MEM_LAT extra cycles; this marks the one that completes
   assign last_cycle = (cnt == LAT);
   // sra/sltu only exist in the 4-bit ALU encoding
   assign alu_ok     = (ALUCTRL_W >= 4) || !funct_alu[3];
   assign state_o    = state;

   // write enables are cut the moment reset rises, not at the next edge
   assign PCWrite  = pcw_en & ~reset;
   assign IRWrite  = irw_en & ~reset;
   assign MemWrite = mem_en & ~reset;
   assign RegWrite = reg_en & ~reset;

   // ALU operation selected by funct3/funct7_5 for R- and I-type instructions
   always_comb begin
      funct_alu = ALU_ADD;
      case (funct3)
         3'b000:  funct_alu = (op[5] & funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  funct_alu = ALU_SLL;
         3'b010:  funct_alu = ALU_SLT;
         3'b011:  funct_alu = ALU_SLTU;
         3'b100:  funct_alu = ALU_XOR;
         3'b101:  funct_alu = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  funct_alu = ALU_OR;
         default: funct_alu = ALU_AND;
      endcase
   end

   // branch condition from the flags of the rs1-rs2 subtraction, and which funct3 are supported
   always_comb begin
      br_legal = 1'b0;
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = Zero;
         3'b001:  br_taken = ~Zero;
         3'b100:  br_taken = Neg ^ Ovf;
         3'b101:  br_taken = ~(Neg ^ Ovf);
         3'b110:  br_taken = ~Carry;
         3'b111:  br_taken = Carry;
         default: br_taken = 1'b0;
      endcase
`ifdef CTRL_EXT_BRANCH_EN
      br_legal = (funct3[2:1] != 2'b01);
`else
      br_legal = (funct3[2:1] == 2'b00);
`endif
   end

   // state, wait counter and sticky trap flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_FETCH;
         cnt       <= 4'd0;
         illegal_o <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state_n == S_TRAP) illegal_o <= 1'b1;
      end
   end

   // next-state sequencing; the counter only runs while a memory state is stalling
   always_comb begin
      state_n = state;
      cnt_n   = 4'd0;
      case (state)
         S_FETCH:    if (last_cycle) state_n = S_DECODE; else cnt_n = cnt + 4'd1;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_n = S_MEMADR;
               OP_R:              state_n = alu_ok ? S_EXECR : S_TRAP;
               OP_I:              state_n = alu_ok ? S_EXECI : S_TRAP;
               OP_BR:             state_n = br_legal ? S_BRANCH : S_TRAP;
               OP_JAL:            state_n = S_JAL;
               OP_JALR:           state_n = S_JALRADR;
               OP_LUI, OP_AUIPC:  state_n = S_EXECU;
               default:           state_n = S_TRAP;
            endcase
         end
         S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (last_cycle) state_n = S_MEMWB; else cnt_n = cnt + 4'd1;
         S_MEMWB:    state_n = S_FETCH;
         S_MEMWRITE: if (last_cycle) state_n = S_FETCH; else cnt_n = cnt + 4'd1;
         S_EXECR, S_EXECI, S_EXECU: state_n = S_ALUWB;
         S_ALUWB:    state_n = S_FETCH;
         S_BRANCH:   state_n = S_FETCH;
         S_JAL:      state_n = S_ALUWB;
         S_JALRADR:  state_n = S_JAL;
         default:    state_n = S_TRAP;
      endcase
   end

   // datapath selects and raw enables per state
   always_comb begin
      pcw_en     = 1'b0;
      irw_en     = 1'b0;
      mem_en     = 1'b0;
      reg_en     = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALUCTRL_W'(ALU_ADD);
      case (state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irw_en    = last_cycle;
            pcw_en    = last_cycle;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR, S_JALRADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_en    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_en = last_cycle;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALUCTRL_W'(funct_alu);
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = ALUCTRL_W'(funct_alu);
         end
         S_ALUWB:    reg_en = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALUCTRL_W'(ALU_SUB);
            pcw_en     = br_taken;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pcw_en  = 1'b1;
         end
         S_EXECU: begin
            ALUSrcA = op[5] ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
         end
         default: ;
      endcase
   end

   // immediate format depends only on the opcode
   always_comb begin
      ImmSrc = 3'b000;
      case (op)
         OP_STORE:         ImmSrc = 3'b001;
         OP_BR:            ImmSrc = 3'b010;
         OP_JAL:           ImmSrc = 3'b011;
         OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
         default:          ImmSrc = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - instruction-level model checks of multicycle_control_unit in two configurations
module tb_multicycle_control_unit;

   typedef struct {
      int st; int pcw; int irw; int mw; int rw;
      int adr; int rs; int a; int b; int alu; int ill;
   } step_t;
   typedef step_t plan_t[$];

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef CTRL_EXT_BRANCH_EN
   localparam int EXT = 1;
`else
   localparam int EXT = 0;
`endif

   logic clk = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // one expected cycle; -1 in a field means the value is not defined for that state
   function automatic step_t mk(int st, int pcw, int irw, int mw, int rw,
                                int adr, int rs, int a, int b, int alu, int ill);
      step_t s;
      s.st = st; s.pcw = pcw; s.irw = irw; s.mw = mw; s.rw = rw;
      s.adr = adr; s.rs = rs; s.a = a; s.b = b; s.alu = alu; s.ill = ill;
      return s;
   endfunction

   function automatic int imm_of(logic [6:0] o);
      case (o)
         OP_LOAD, OP_I, OP_JALR: return 0;
         OP_STORE:               return 1;
         OP_BR:                  return 2;
         OP_JAL:                 return 3;
         OP_LUI, OP_AUIPC:       return 4;
         default:                return -1;
      endcase
   endfunction

   function automatic int alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
      case (f3)
         3'd0:    return (o[5] && f7) ? 1 : 0;
         3'd1:    return 6;
         3'd2:    return 5;
         3'd3:    return 9;
         3'd4:    return 4;
         3'd5:    return f7 ? 8 : 7;
         3'd6:    return 3;
         default: return 2;
      endcase
   endfunction

   // fl = {Zero, Neg, Ovf, Carry}
   function automatic int br_of(logic [2:0] f3, logic [3:0] fl);
      case (f3)
         3'd0:    return int'(fl[3]);
         3'd1:    return int'(!fl[3]);
         3'd4:    return int'(fl[2] ^ fl[1]);
         3'd5:    return int'(!(fl[2] ^ fl[1]));
         3'd6:    return int'(!fl[0]);
         3'd7:    return int'(fl[0]);
         default: return 0;
      endcase
   endfunction

   // whole-instruction cycle trace from the instruction class, latency and ALU width
   function automatic plan_t build(logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] fl, int lat, int w);
      plan_t p;
      int    code = alu_of(o, f3, f7);
      int    tk = br_of(f3, fl);
      bit    trap = 1'b0;
      step_t aluwb = mk(8, 0, 0, 0, 1, -1, 0, -1, -1, -1, 0);
      step_t jal = mk(10, 1, 0, 0, 0, -1, 0, 1, 2, 0, 0);
      step_t madr = mk(2, 0, 0, 0, 0, -1, -1, 2, 1, 0, 0);
      for (int i = 0; i <= lat; i++) p.push_back(mk(0, int'(i == lat), int'(i == lat), 0, 0, 0, 2, 0, 2, 0, 0));
      p.push_back(mk(1, 0, 0, 0, 0, -1, -1, 1, 1, 0, 0));
      case (o)
         OP_LOAD: begin
            p.push_back(madr);
            for (int i = 0; i <= lat; i++) p.push_back(mk(3, 0, 0, 0, 0, 1, 0, -1, -1, -1, 0));
            p.push_back(mk(4, 0, 0, 0, 1, -1, 1, -1, -1, -1, 0));
         end
         OP_STORE: begin
            p.push_back(madr);
            for (int i = 0; i <= lat; i++) p.push_back(mk(5, 0, 0, int'(i == lat), 0, 1, 0, -1, -1, -1, 0));
         end
         OP_R, OP_I: begin
            if (w == 3 && code >= 8) trap = 1'b1;
            else begin
               p.push_back(mk((o == OP_R) ? 6 : 7, 0, 0, 0, 0, -1, -1, 2, (o == OP_R) ? 0 : 1, code, 0));
               p.push_back(aluwb);
            end
         end
         OP_BR: begin
            if (f3 == 3'd2 || f3 == 3'd3 || (f3 >= 3'd4 && EXT == 0)) trap = 1'b1;
            else p.push_back(mk(9, tk, 0, 0, 0, -1, 0, 2, 0, 1, 0));
         end
         OP_JAL: begin
            p.push_back(jal);
            p.push_back(aluwb);
         end
         OP_JALR: begin
            p.push_back(mk(11, 0, 0, 0, 0, -1, -1, 2, 1, 0, 0));
            p.push_back(jal);
            p.push_back(aluwb);
         end
         OP_LUI, OP_AUIPC: begin
            p.push_back(mk(12, 0, 0, 0, 0, -1, -1, o[5] ? 3 : 1, 1, 0, 0));
            p.push_back(aluwb);
         end
         default: trap = 1'b1;
      endcase
      if (trap) for (int i = 0; i < 10; i++) p.push_back(mk(15, 0, 0, 0, 0, -1, -1, -1, -1, -1, (i == 0) ? -1 : 1));
      return p;
   endfunction

   task automatic chk(int g, string nm, int act, int exp);
      if (exp >= 0) begin
         n_checks++;
         if (act != exp) begin
            n_errors++;
            $display("FAIL u%0d %s: got %0d, expected %0d at %0t", g, nm, act, exp, $time);
         end
      end
   endtask

   task automatic chk_seq(int g, string nm, int act[$], int exp[$]);
      chk(g, {nm, " length"}, act.size(), exp.size());
      for (int i = 0; i < exp.size() && i < act.size(); i++)
         chk(g, $sformatf("%s[%0d]", nm, i), act[i], exp[i]);
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int W   = (g == 0) ? 3 : 4;
      localparam int LAT = (g == 0) ? 0 : 2;

      logic         rst;
      logic [6:0]   op;
      logic [2:0]   f3;
      logic         f7;
      logic [3:0]   fl;
      logic         pcw, adr, mw, irw, rw, ill;
      logic [1:0]   rs, sa, sb;
      logic [2:0]   imm;
      logic [W-1:0] alu;
      logic [3:0]   st;
      logic         fin = 1'b0;
      plan_t        plan;
      int           seen[$];
      int           exec_alu, br_pcw, last_ill;

      multicycle_control_unit #(.ALUCTRL_W(W), .MEM_LAT(LAT)) dut (
         .clk(clk), .reset(rst), .op(op), .funct3(f3), .funct7_5(f7),
         .Zero(fl[3]), .Neg(fl[2]), .Ovf(fl[1]), .Carry(fl[0]),
         .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw), .RegWrite(rw),
         .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb), .ImmSrc(imm), .ALUControl(alu),
         .state_o(st), .illegal_o(ill)
      );

      task automatic check_step(step_t e);
         chk(g, "state_o", int'(st), e.st);
         chk(g, "PCWrite", int'(pcw), e.pcw);
         chk(g, "IRWrite", int'(irw), e.irw);
         chk(g, "MemWrite", int'(mw), e.mw);
         chk(g, "RegWrite", int'(rw), e.rw);
         chk(g, "AdrSrc", int'(adr), e.adr);
         chk(g, "ResultSrc", int'(rs), e.rs);
         chk(g, "ALUSrcA", int'(sa), e.a);
         chk(g, "ALUSrcB", int'(sb), e.b);
         chk(g, "ALUControl", int'(alu), e.alu);
         chk(g, "ImmSrc", int'(imm), imm_of(op));
         chk(g, "illegal_o", int'(ill), e.ill);
      endtask

      // entered just after a rising edge; leaves just after the edge that starts a fresh FETCH
      task automatic do_reset();
         step_t r = mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
         rst = 1'b1;
         #1;
         check_step(r);
         @(negedge clk);
         check_step(r);
         @(posedge clk);
         #1;
         rst = 1'b0;
      endtask

      task automatic run_instr(logic [6:0] o, logic [2:0] ff3, logic ff7, logic [3:0] ffl, int abort_at);
         op = o; f3 = ff3; f7 = ff7; fl = ffl;
         plan = build(o, ff3, ff7, ffl, LAT, W);
         seen.delete();
         exec_alu = 0; br_pcw = 0; last_ill = 0;
         for (int k = 0; k < plan.size(); k++) begin
            if (k == abort_at) begin
               do_reset();
               return;
            end
            @(negedge clk);
            check_step(plan[k]);
            seen.push_back(int'(st));
            if (st == 4'd6 || st == 4'd7) exec_alu = int'(alu);
            if (st == 4'd9) br_pcw = int'(pcw);
            last_ill = int'(ill);
            @(posedge clk);
            #1;
         end
         if (plan[plan.size() - 1].st == 15) do_reset();
      endtask

      initial begin
         int e[$];
         rst = 1'b1; op = OP_LOAD; f3 = 3'd2; f7 = 1'b0; fl = 4'd0;
         #2;
         do_reset();

         run_instr(OP_LOAD, 3'd2, 1'b0, 4'd0, -1);
         if (LAT == 0) e = '{0, 1, 2, 3, 4}; else e = '{0, 0, 0, 1, 2, 3, 3, 3, 4};
         chk_seq(g, "lw states", seen, e);

         run_instr(OP_STORE, 3'd2, 1'b0, 4'd0, -1);
         if (LAT == 0) e = '{0, 1, 2, 5}; else e = '{0, 0, 0, 1, 2, 5, 5, 5};
         chk_seq(g, "sw states", seen, e);

         run_instr(OP_R, 3'd0, 1'b1, 4'd0, -1);
         chk(g, "sub ALUControl", exec_alu, 1);

         run_instr(OP_R, 3'd5, 1'b1, 4'd0, -1);
         chk(g, "sra ALUControl", exec_alu, (W == 4) ? 8 : 0);
         chk(g, "sra illegal_o", last_ill, (W == 3) ? 1 : 0);

         run_instr(OP_JALR, 3'd0, 1'b0, 4'd0, -1);
         if (LAT == 0) e = '{0, 1, 11, 10, 8}; else e = '{0, 0, 0, 1, 11, 10, 8};
         chk_seq(g, "jalr states", seen, e);

         run_instr(OP_BR, 3'd0, 1'b0, 4'b1000, -1);
         chk(g, "beq Zero=1 PCWrite", br_pcw, 1);
         run_instr(OP_BR, 3'd1, 1'b0, 4'b1000, -1);
         chk(g, "bne Zero=1 PCWrite", br_pcw, 0);
         run_instr(OP_BR, 3'd4, 1'b0, 4'b0100, -1);
         chk(g, "blt PCWrite", br_pcw, EXT);
         chk(g, "blt illegal_o", last_ill, 1 - EXT);

         run_instr(7'b1111111, 3'd0, 1'b0, 4'd0, -1);
         chk(g, "bad op illegal_o", last_ill, 1);
         chk(g, "bad op trace length", seen.size(), LAT + 12);

         run_instr(OP_STORE, 3'd2, 1'b0, 4'd0, 2 * LAT + 3);

         for (int n = 0; n < 150; n++) begin
            logic [6:0] o;
            int         pick;
            int         ab;
            pick = $urandom_range(0, 10);
            case (pick)
               0:       o = OP_LOAD;
               1:       o = OP_STORE;
               2:       o = OP_R;
               3:       o = OP_I;
               4:       o = OP_BR;
               5:       o = OP_JAL;
               6:       o = OP_JALR;
               7:       o = OP_LUI;
               8:       o = OP_AUIPC;
               default: o = 7'($urandom);
            endcase
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), 4'($urandom), ab);
         end
         fin = 1'b1;
      end
   end

   initial begin
      int cyc = 0;
      while (!(u[0].fin && u[1].fin) && cyc < 50000) begin
         @(posedge clk);
         cyc++;
      end
      if (!(u[0].fin && u[1].fin)) begin
         n_checks++;
         n_errors++;
         $display("FAIL completion: got not done after %0d cycles, expected done", cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
